// File: rtl/uart_pkg.sv
// Shared constants for the UART byte-buffer FIFO controllers.
package uart_pkg;

  localparam int UART_FIFO_WIDTH = 8;
  localparam int UART_FIFO_DEPTH = 16;

  // Occupancy width: one extra bit so a full RAM plus the output slot fits.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int UART_FIFO_CNT_W = fifo_cnt_w(UART_FIFO_DEPTH);

endpackage

// File: rtl/uart_fifo_ctrl.sv
// FIFO controller for an external sync dual-port RAM (A write, B read) that
// presents the RAM's one-cycle read latency as a first-word-fall-through stream.
module uart_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int  WIDTH = UART_FIFO_WIDTH,
  parameter int  DEPTH = UART_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = fifo_cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             ram_ena,
  output logic             ram_wea,
  output logic [AW-1:0]    ram_addra,
  output logic [WIDTH-1:0] ram_dina,
  output logic             ram_enb,
  output logic             ram_web,
  output logic [AW-1:0]    ram_addrb,
  input  logic [WIDTH-1:0] ram_doutb
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] mem_cnt_q, mem_cnt_d;
  logic          m_valid_q, m_valid_d;
  logic          ovf_q, ovf_d;
  logic          push, fetch;

  assign s_ready = (mem_cnt_q != FULL_CNT);
  assign push    = s_valid & s_ready & ~flush;
  // Refill the output slot when it is empty or being consumed this cycle.
  assign fetch   = (mem_cnt_q != '0) & (~m_valid_q | m_ready) & ~flush;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    mem_cnt_d = mem_cnt_q;
    m_valid_d = m_valid_q;
    ovf_d     = ovf_q;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      mem_cnt_d = '0;
      m_valid_d = 1'b0;
      ovf_d     = 1'b0;
    end else begin
      if (push)  wr_ptr_d = wr_ptr_q + AW'(1);
      if (fetch) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, fetch})
        2'b10:   mem_cnt_d = mem_cnt_q + CW'(1);
        2'b01:   mem_cnt_d = mem_cnt_q - CW'(1);
        default: mem_cnt_d = mem_cnt_q;
      endcase
      if (fetch)        m_valid_d = 1'b1;
      else if (m_ready) m_valid_d = 1'b0;
      if (s_valid & ~s_ready) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_cnt_q <= '0;
      m_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      mem_cnt_q <= mem_cnt_d;
      m_valid_q <= m_valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign empty     = ~m_valid_q;
  assign full      = ~s_ready;
  assign count     = mem_cnt_q + CW'(m_valid_q);
  assign ovf       = ovf_q;
  assign ram_ena   = push;
  assign ram_wea   = push;
  assign ram_addra = wr_ptr_q;
  assign ram_dina  = s_data;
  assign ram_enb   = fetch;
  assign ram_web   = 1'b0;
  assign ram_addrb = rd_ptr_q;
  // The RAM holds its output while ram_enb is low, keeping m_data stable.
  assign m_data    = ram_doutb;

endmodule
